wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-producer FIFOs merged round-robin onto one register-file write port.
// Define WB_SCOREBOARD_EN to add pend_mask, a bitmap of destination registers with writes outstanding.
module wb_arbiter #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REG_W    = 5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [CHANNELS-1:0]        ch_valid,
  output logic [CHANNELS-1:0]        ch_ready,
  input  logic [CHANNELS*REG_W-1:0]  ch_regdst,
  input  logic [CHANNELS*WORD_W-1:0] ch_wdat,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       WEN,
  output logic [REG_W-1:0]           wsel,
  output logic [WORD_W-1:0]          wdat,
  output logic                       busy
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [2**REG_W-1:0]        pend_mask
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [REG_W-1:0]  r_reg_mem [CHANNELS][DEPTH];
  logic [WORD_W-1:0] r_dat_mem [CHANNELS][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr  [CHANNELS];
  logic [PTR_W-1:0]  r_rd_ptr  [CHANNELS];
  logic [CNT_W-1:0]  r_count   [CHANNELS];
  logic [CH_W-1:0]   r_rr_ptr;

  logic [CHANNELS-1:0] w_nonempty;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_pop;
  logic [CH_W-1:0]     w_idx [CHANNELS];
  logic                w_grant_vld;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_deq;
  logic [REG_W-1:0]    w_head_reg;
  logic [WORD_W-1:0]   w_head_dat;

  // Ready depends on occupancy only; register-0 writes are acknowledged but never stored.
  always_comb begin
    w_nonempty = '0;
    ch_ready   = '0;
    w_push     = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      ch_ready[i]   = (r_count[i] != CNT_W'(DEPTH));
      w_push[i]     = ch_valid[i] && ch_ready[i] && !flush &&
                      (ch_regdst[i*REG_W +: REG_W] != '0);
    end
  end

  assign busy = |w_nonempty;

  // Round-robin search from r_rr_ptr; scanning backwards lets the closest candidate win.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      w_idx[k] = CH_W'((int'(r_rr_ptr) + k) % int'(CHANNELS));
    end
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (w_nonempty[w_idx[k]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx[k];
      end
    end
    w_deq      = w_grant_vld && !stall && !flush;
    w_head_reg = r_reg_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    w_head_dat = r_dat_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
    w_pop      = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_pop[i] = w_deq && (w_grant_idx == CH_W'(i));
    end
  end

  // FIFO storage needs no reset: occupancy is governed by the counters.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (w_push[i]) begin
        r_reg_mem[i][r_wr_ptr[i]] <= ch_regdst[i*REG_W +: REG_W];
        r_dat_mem[i][r_wr_ptr[i]] <= ch_wdat[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_rr_ptr <= '0;
      WEN      <= 1'b0;
      wsel     <= '0;
      wdat     <= '0;
    end else if (flush) begin
      // Flush empties every queue but keeps the arbitration position.
      for (int i = 0; i < int'(CHANNELS); i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      WEN <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        unique case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
      WEN <= w_deq;
      if (w_deq) begin
        wsel     <= w_head_reg;
        wdat     <= w_head_dat;
        r_rr_ptr <= CH_W'((int'(w_grant_idx) + 1) % int'(CHANNELS));
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  // Slot k of FIFO i is live when its distance from the read pointer is below the count.
  always_comb begin
    pend_mask = '0;
    if (WEN) pend_mask[wsel] = 1'b1;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if ({1'b0, PTR_W'(PTR_W'(k) - r_rd_ptr[i])} < r_count[i]) begin
          pend_mask[r_reg_mem[i][k]] = 1'b1;
        end
      end
    end
    pend_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued by the stimulus and
// checked by an independent monitor whenever WEN is seen high.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned REG_W    = 5;

  typedef struct packed {
    logic [REG_W-1:0]  sel;
    logic [WORD_W-1:0] dat;
  } wr_t;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic [CHANNELS-1:0]        ch_valid;
  logic [CHANNELS-1:0]        ch_ready;
  logic [CHANNELS*REG_W-1:0]  ch_regdst;
  logic [CHANNELS*WORD_W-1:0] ch_wdat;
  logic                       stall;
  logic                       flush;
  logic                       WEN;
  logic [REG_W-1:0]           wsel;
  logic [WORD_W-1:0]          wdat;
  logic                       busy;
`ifdef WB_SCOREBOARD_EN
  logic [2**REG_W-1:0]        pend_mask;
`endif

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  wb_arbiter #(
    .CHANNELS(CHANNELS), .DEPTH(DEPTH), .WORD_W(WORD_W), .REG_W(REG_W)
  ) dut (
    .CLK(CLK), .RST(RST),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_regdst(ch_regdst), .ch_wdat(ch_wdat),
    .stall(stall), .flush(flush),
    .WEN(WEN), .wsel(wsel), .wdat(wdat),
`ifdef WB_SCOREBOARD_EN
    .pend_mask(pend_mask),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic [REG_W-1:0] r,
                       input logic [WORD_W-1:0] d);
    ch_valid[ch]                      = v;
    ch_regdst[ch*REG_W +: REG_W]      = r;
    ch_wdat[ch*WORD_W +: WORD_W]      = d;
  endtask

  task automatic expect_wr(input logic [REG_W-1:0] r, input logic [WORD_W-1:0] d);
    wr_t e;
    e.sel = r;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30; k++) begin
      if (!busy && !WEN) break;
      step();
    end
    check({name, "_idle"}, 64'({busy, WEN}), 64'(0));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: every write on the register-file port must match the oldest expectation.
  always @(negedge CLK) begin : mon
    wr_t e;
    if (WEN === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got wsel=%0d wdat=%0h expected no write", wsel, wdat);
      end else begin
        e = exp_q.pop_front();
        if (wsel !== e.sel || wdat !== e.dat) begin
          n_fail++;
          $display("FAIL sb_write: got wsel=%0d wdat=%0h expected wsel=%0d wdat=%0h",
                   wsel, wdat, e.sel, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    ch_valid = '0; ch_regdst = '0; ch_wdat = '0;

    // Reset held two cycles with every producer requesting
    for (int i = 0; i < int'(CHANNELS); i++) drive(i, 1'b1, REG_W'(i + 1), WORD_W'(32'hF0 + i));
    step(); step();
    RST = 1'b0; ch_valid = '0;
    check("reset_wen",   64'(WEN), 64'(0));
    check("reset_busy",  64'(busy), 64'(0));
    check("reset_ready", 64'(ch_ready), 64'(3'b111));
    step();
    check("post_reset_busy",  64'(busy), 64'(0));
    check("post_reset_ready", 64'(ch_ready), 64'(3'b111));

    // Round robin: three channels enqueue on one edge
    drive(0, 1'b1, 5'd1, 32'hA); drive(1, 1'b1, 5'd2, 32'hB); drive(2, 1'b1, 5'd3, 32'hC);
    expect_wr(5'd1, 32'hA); expect_wr(5'd2, 32'hB); expect_wr(5'd3, 32'hC);
    step();
    ch_valid = '0;
    check("rr_lat_wen0", 64'(WEN), 64'(0));
    check("rr_busy",     64'(busy), 64'(1));
    step();
    check("rr_wen1", 64'(WEN), 64'(1));
    check("rr_sel1", 64'(wsel), 64'(1));
    step();
    check("rr_wen2", 64'(WEN), 64'(1));
    check("rr_sel2", 64'(wsel), 64'(2));
    step();
    check("rr_wen3", 64'(WEN), 64'(1));
    check("rr_sel3", 64'(wsel), 64'(3));
    step();
    check("rr_done_wen",  64'(WEN), 64'(0));
    check("rr_done_busy", 64'(busy), 64'(0));

    // Full FIFO under stall, then release
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("full_ready_pre", 64'(ch_ready[0]), 64'(1));
      drive(0, 1'b1, REG_W'(4 + k), WORD_W'(32'h100 + k));
      expect_wr(REG_W'(4 + k), WORD_W'(32'h100 + k));
      step();
    end
    drive(0, 1'b1, 5'd8, 32'h104);
    expect_wr(5'd8, 32'h104);
    check("full_ready0", 64'(ch_ready[0]), 64'(0));
    step();
    check("full_ready_held", 64'(ch_ready[0]), 64'(0));
    check("full_stall_wen",  64'(WEN), 64'(0));
    stall = 1'b0;
    step();
    check("full_first_wen", 64'(WEN), 64'(1));
    check("full_first_sel", 64'(wsel), 64'(4));
    check("full_ready_free", 64'(ch_ready[0]), 64'(1));
    step();
    ch_valid = '0;
    drain("full");

    // Register-0 write: accepted, never stored
    drive(1, 1'b1, 5'd0, 32'hDEAD);
    check("reg0_ready", 64'(ch_ready[1]), 64'(1));
    step();
    ch_valid = '0;
    check("reg0_busy", 64'(busy), 64'(0));
    check("reg0_wen",  64'(WEN), 64'(0));
    step();
    check("reg0_busy2", 64'(busy), 64'(0));
    check("reg0_wen2",  64'(WEN), 64'(0));

    // Stall holds two entries, then flush (with stall and a same-cycle request)
    stall = 1'b1;
    drive(2, 1'b1, 5'd9, 32'h900);
    step();
    drive(2, 1'b1, 5'd10, 32'h901);
    step();
    ch_valid = '0;
    for (int k = 0; k < 3; k++) begin
      check("stall_wen",  64'(WEN), 64'(0));
      check("stall_busy", 64'(busy), 64'(1));
      step();
    end
    flush = 1'b1;
    drive(0, 1'b1, 5'd11, 32'h911);
    step();
    flush = 1'b0; stall = 1'b0; ch_valid = '0;
    check("flush_busy",  64'(busy), 64'(0));
    check("flush_wen",   64'(WEN), 64'(0));
    check("flush_ready", 64'(ch_ready), 64'(3'b111));
    step();
    check("flush_wen2",  64'(WEN), 64'(0));
    check("flush_busy2", 64'(busy), 64'(0));

    // Pointer sits at channel 1: channel 2 must beat channel 0
    drive(0, 1'b1, 5'd12, 32'hC0); drive(2, 1'b1, 5'd13, 32'hC2);
    expect_wr(5'd13, 32'hC2); expect_wr(5'd12, 32'hC0);
    step();
    ch_valid = '0;
    step();
    check("rrptr_sel_first", 64'(wsel), 64'(13));
    step();
    check("rrptr_sel_second", 64'(wsel), 64'(12));
    drain("rrptr");

`ifdef WB_SCOREBOARD_EN
    // Pending-register bitmap follows reg 7 through queue and output
    check("pm_idle", 64'(pend_mask[7]), 64'(0));
    drive(1, 1'b1, 5'd7, 32'h77);
    expect_wr(5'd7, 32'h77);
    step();
    ch_valid = '0;
    check("pm_queued", 64'(pend_mask[7]), 64'(1));
    step();
    check("pm_out_wen", 64'(WEN), 64'(1));
    check("pm_out",     64'(pend_mask[7]), 64'(1));
    step();
    check("pm_cleared", 64'(pend_mask[7]), 64'(0));
    check("pm_bit0",    64'(pend_mask[0]), 64'(0));
`endif

    // Reset in the middle of a drain: only the first write may appear
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, REG_W'(k + 1), WORD_W'(32'hD1 + k));
      step();
    end
    ch_valid = '0;
    expect_wr(5'd1, 32'hD1);
    stall = 1'b0;
    step();
    check("mid_wen", 64'(WEN), 64'(1));
    check("mid_sel", 64'(wsel), 64'(1));
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_rst_wen",   64'(WEN), 64'(0));
    check("mid_rst_busy",  64'(busy), 64'(0));
    check("mid_rst_ready", 64'(ch_ready), 64'(3'b111));
    step(); step();
    check("mid_rst_wen2", 64'(WEN), 64'(0));
    check("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
